tol_vector_checker: RTL

- Synthesizable, parametrised result checker for the frequency-analysis datapath (FIR stream, multi-bin FFT vectors).
- Buffers golden vectors in a FIFO and compares each DUT result vector lane-by-lane within a ±TOL modular window.
- Accumulates per-lane mismatches, aborts at a fail limit, and reports PASS/FAIL plus first-error location.
- One instance per result stream: LANES=1 for FIR, LANES=16 for FFT.

---
 rtl/tol_vector_checker_if.sv | 22 ++
 rtl/tol_vector_checker.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tol_vector_checker_if.sv
// Stream bundle between a stimulus source and the tolerance checker:
// the golden push channel and the DUT result channel.
interface tol_vector_checker_if #(
    parameter int DW    = 16,
    parameter int LANES = 16
);
    logic                  gld_valid;
    logic [LANES*DW-1:0]   gld_data;
    logic                  gld_ready;
    logic                  dut_valid;
    logic [LANES*DW-1:0]   dut_data;

    modport master (
        output gld_valid, gld_data, dut_valid, dut_data,
        input  gld_ready
    );

    modport slave (
        input  gld_valid, gld_data, dut_valid, dut_data,
        output gld_ready
    );
endinterface

// File: rtl/tol_vector_checker.sv
// Result checker: buffers golden vectors in a FIFO and compares each DUT
// vector lane-by-lane within a +/-TOL modular window, accumulating failures
// and reporting PASS/FAIL with the location of the first failing vector.
module tol_vector_checker #(
    parameter int DW         = 16,
    parameter int LANES      = 16,
    parameter int TOL        = 3,
    parameter int DEPTH      = 8,
    parameter int NUM_VEC    = 64,
    parameter int FAIL_LIMIT = 48,
    parameter int CNT_W      = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    tol_vector_checker_if.slave  bus,
    output logic                 err_valid,
    output logic [LANES-1:0]     err_mask,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [CNT_W-1:0]     vec_cnt,
    output logic [CNT_W-1:0]     first_err_vec,
    output logic                 underflow,
    output logic                 done,
    output logic                 pass
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FAIL_LIM_C = CNT_W'(FAIL_LIMIT);
    localparam logic [CNT_W-1:0] NUM_VEC_C  = CNT_W'(NUM_VEC);
    localparam logic [AW:0]      DEPTH_C    = (AW+1)'(DEPTH);
    // Lane difference is taken modulo 2^DW; these bound the accepted window
    // [0, TOL] U [2^DW - TOL, 2^DW - 1]. With TOL=0 the upper bound is 2^DW,
    // which no DW-bit difference reaches, so only exact matches pass.
    localparam logic [DW:0]      TOL_LO     = (DW+1)'(TOL);
    localparam logic [DW:0]      TOL_HI     = {1'b1, {DW{1'b0}}} - TOL_LO;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t state, state_nxt;

    logic [LANES*DW-1:0] mem [DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                full, empty;
    logic [LANES*DW-1:0] head;
    logic [LANES-1:0]    cmp_mask;
    logic                run, push, do_cmp, do_uf;
    logic [CNT_W-1:0]    fail_upd, vec_upd;

    function automatic logic lane_fails(input logic [DW-1:0] dut_l,
                                        input logic [DW-1:0] gld_l);
        logic [DW:0] d;
        d = {1'b0, dut_l - gld_l};
        return !((d <= TOL_LO) || (d >= TOL_HI));
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) c = c + CNT_W'(m[i]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign full     = ((wr_ptr - rd_ptr) == DEPTH_C);
    assign empty    = (wr_ptr == rd_ptr);
    assign head     = mem[rd_ptr[AW-1:0]];
    assign run      = (state == S_RUN);
    assign push     = run && bus.gld_valid && !full && !start;
    assign do_cmp   = run && bus.dut_valid && !empty;
    assign do_uf    = run && bus.dut_valid && empty;
    assign fail_upd = sat_add(fail_cnt, popcount(cmp_mask));
    assign vec_upd  = vec_cnt + 1'b1;

    // Per-lane tolerance test of the incoming DUT vector against the FIFO head
    always_comb begin
        cmp_mask = '0;
        for (int i = 0; i < LANES; i++)
            cmp_mask[i] = lane_fails(bus.dut_data[i*DW +: DW], head[i*DW +: DW]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state from the post-compare counter values, plus state-derived outputs
    always_comb begin
        state_nxt     = state;
        bus.gld_ready = 1'b0;
        done          = 1'b0;
        pass          = 1'b0;
        if (start) begin
            state_nxt = S_RUN;
        end else if (do_uf) begin
            state_nxt = S_FAIL;
        end else if (do_cmp) begin
            if (fail_upd >= FAIL_LIM_C)
                state_nxt = S_FAIL;
            else if (vec_upd == NUM_VEC_C)
                state_nxt = (fail_upd == '0) ? S_PASS : S_FAIL;
        end
        bus.gld_ready = run && !full;
        done          = (state == S_PASS) || (state == S_FAIL);
        pass          = (state == S_PASS);
    end

    // Golden vector storage; contents need no reset, only the pointers do
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.gld_data;
    end

    // FIFO pointers, result registers and run counters
    always_ff @(posedge clk) begin
        if (rst || start) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            err_valid     <= 1'b0;
            err_mask      <= '0;
            fail_cnt      <= '0;
            vec_cnt       <= '0;
            first_err_vec <= '1;
            underflow     <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_cmp) begin
                rd_ptr    <= rd_ptr + 1'b1;
                err_mask  <= cmp_mask;
                err_valid <= |cmp_mask;
                fail_cnt  <= fail_upd;
                vec_cnt   <= vec_upd;
                // fail_cnt still zero means no earlier vector has failed
                if (|cmp_mask && fail_cnt == '0) first_err_vec <= vec_cnt;
            end
            if (do_uf) underflow <= 1'b1;
        end
    end
endmodule
